// File: rtl/sfifo_param.sv
// Single-clock parametrised FIFO with occupancy count, AF/AE thresholds,
// sticky overflow/underflow flags and selectable FWFT or registered read port.
module sfifo_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1,
  parameter bit          FWFT     = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       push,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rdata,
  output logic                       rvalid,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       clr_err,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              push_ok, pop_ok;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // No pass-through when full, no bypass when empty: acceptance uses registered state only.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  // A new error in the same cycle as clr_err wins and keeps its flag set.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (push && full)  ovf_d = 1'b1;
    if (pop && empty)  udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wptr_q] <= wdata;
  end

  generate
    if (FWFT) begin : g_fwft
      assign rvalid = !empty;
      assign rdata  = empty ? '0 : mem_q[rptr_q];
    end else begin : g_reg
      logic [DATA_W-1:0] rdata_q;
      logic              rvalid_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= pop_ok;
          if (pop_ok) rdata_q <= mem_q[rptr_q];
        end
      end
      assign rvalid = rvalid_q;
      assign rdata  = rdata_q;
    end
  endgenerate
endmodule

// File: tb/tb_sfifo_param.sv
// Bench for sfifo_param: an FWFT instance and a registered-read instance share
// stimulus and are compared each cycle against a queue-based reference model.
module tb_sfifo_param;
  localparam int DW = 32;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic push = 1'b0, pop = 1'b0, clr_err = 1'b0;

  logic full1, af1, empty1, ae1, rvalid1, ovf1, udf1;
  logic [DW-1:0] rdata1;
  logic [3:0] count1;
  logic full0, af0, empty0, ae0, rvalid0, ovf0, udf0;
  logic [DW-1:0] rdata0;
  logic [3:0] count0;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] mq [$];
  bit ovf_m = 0, udf_m = 0, rv0_m = 0;
  logic [DW-1:0] rd0_m = '0;

  always #5 clk = ~clk;

  sfifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .wdata(wdata), .push(push), .full(full1),
    .almost_full(af1), .pop(pop), .rdata(rdata1), .rvalid(rvalid1),
    .empty(empty1), .almost_empty(ae1), .count(count1), .clr_err(clr_err),
    .overflow(ovf1), .underflow(udf1));

  // Registered read with thresholds at their extreme legal values.
  sfifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(DEPTH), .AE_LEVEL(0),
                .FWFT(1'b0)) u_reg (
    .clk(clk), .rst(rst), .wdata(wdata), .push(push), .full(full0),
    .almost_full(af0), .pop(pop), .rdata(rdata0), .rvalid(rvalid0),
    .empty(empty0), .almost_empty(ae0), .count(count0), .clr_err(clr_err),
    .overflow(ovf0), .underflow(udf0));

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = mq.size();
    chk("count1", DW'(count1), DW'(sz));
    chk("full1", DW'(full1), DW'(sz == DEPTH));
    chk("empty1", DW'(empty1), DW'(sz == 0));
    chk("af1", DW'(af1), DW'(sz >= DEPTH - 1));
    chk("ae1", DW'(ae1), DW'(sz <= 1));
    chk("ovf1", DW'(ovf1), DW'(ovf_m));
    chk("udf1", DW'(udf1), DW'(udf_m));
    chk("rvalid1", DW'(rvalid1), DW'(sz != 0));
    chk("rdata1", rdata1, (sz != 0) ? mq[0] : '0);
    chk("count0", DW'(count0), DW'(sz));
    chk("af0", DW'(af0), DW'(sz >= DEPTH));
    chk("ae0", DW'(ae0), DW'(sz == 0));
    chk("ovf0", DW'(ovf0), DW'(ovf_m));
    chk("udf0", DW'(udf0), DW'(udf_m));
    chk("rvalid0", DW'(rvalid0), DW'(rv0_m));
    chk("rdata0", rdata0, rd0_m);
  endtask

  // One clock: model consumes the inputs as seen at the edge, outputs checked 1ns later.
  task automatic cycle();
    int sz;
    bit pa, pp;
    @(posedge clk);
    sz = mq.size();
    if (rst) begin
      mq.delete();
      ovf_m = 0; udf_m = 0; rv0_m = 0; rd0_m = '0;
    end else begin
      pa = push && (sz < DEPTH);
      pp = pop && (sz > 0);
      if (clr_err) begin ovf_m = 0; udf_m = 0; end
      if (push && sz == DEPTH) ovf_m = 1;
      if (pop && sz == 0) udf_m = 1;
      rv0_m = pp;
      if (pp) rd0_m = mq.pop_front();
      if (pa) mq.push_back(wdata);
    end
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    push = 0; pop = 0; clr_err = 0; rst = 0;
  endtask

  initial begin
    // Reset and fill
    rst = 1; cycle(); cycle(); rst = 0;
    chk("rst_empty", DW'(empty1), 1);
    chk("rst_rdata0", rdata0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      push = 1; wdata = DW'(i); cycle();
      if (i == DEPTH - 2) chk("af_at7", DW'(af1), 1);
    end
    push = 0;
    chk("fill_count", DW'(count1), DEPTH);
    chk("fill_full", DW'(full1), 1);

    // Overflow with simultaneous pop, then clear
    push = 1; pop = 1; wdata = 32'hAA; cycle();
    chk("ovf_count", DW'(count1), 7);
    chk("ovf_set", DW'(ovf1), 1);
    push = 0; pop = 0; clr_err = 1; cycle(); clr_err = 0;
    chk("ovf_clr", DW'(ovf1), 0);
    for (int i = 1; i < DEPTH; i++) begin
      chk("drain_seq", rdata1, DW'(i));
      pop = 1; cycle();
    end
    pop = 0;

    // Underflow with simultaneous push on empty
    chk("empty_rdata", rdata1, 0);
    pop = 1; push = 1; wdata = 32'h55; cycle(); idle_inputs();
    chk("udf_set", DW'(udf1), 1);
    chk("udf_count", DW'(count1), 1);
    chk("udf_rdata", rdata1, 32'h55);
    pop = 1; cycle(); pop = 0; clr_err = 1; cycle(); clr_err = 0;

    // Wrap-around streaming at count 3
    for (int i = 0; i < 3; i++) begin push = 1; wdata = 32'h100 + DW'(i); cycle(); end
    for (int i = 0; i < 20; i++) begin
      push = 1; pop = 1; wdata = 32'h200 + DW'(i); cycle();
    end
    chk("wrap_count", DW'(count1), 3);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin pop = 1; cycle(); end
    pop = 0;

    // Registered-read sequence
    push = 1; wdata = 32'h11; cycle(); wdata = 32'h22; cycle(); push = 0;
    pop = 1; cycle();
    chk("reg_d0", rdata0, 32'h11);
    cycle(); pop = 0;
    chk("reg_d1", rdata0, 32'h22);
    cycle();
    chk("reg_rv_lo", DW'(rvalid0), 0);
    chk("reg_hold", rdata0, 32'h22);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) begin push = 1; wdata = 32'h300 + DW'(i); cycle(); end
    rst = 1; push = 1; pop = 1; cycle(); idle_inputs();
    chk("mid_count", DW'(count1), 0);
    chk("mid_empty", DW'(empty1), 1);
    push = 1; wdata = 32'h99; cycle(); push = 0;
    chk("mid_head", rdata1, 32'h99);
    pop = 1; cycle(); pop = 0;
    chk("mid_reg", rdata0, 32'h99);

    // Randomised traffic with occasional reset and error clears
    for (int i = 0; i < 600; i++) begin
      push = ($urandom_range(99) < 55);
      pop = ($urandom_range(99) < 50);
      clr_err = ($urandom_range(99) < 8);
      rst = ($urandom_range(99) < 2);
      wdata = $urandom;
      cycle();
    end
    idle_inputs();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
